// File: rtl/lcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_ctrl_pkg
//  Purpose  : Shared FSM states, HD44780 command bytes and timing defaults.
//  Revision : 1.0 - initial release
// ============================================================================
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_SETUP   = 3'd1,
        ST_EN_HIGH = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4
    } lcd_state_t;

    localparam logic [7:0] c_cmd_func_set = 8'h38;
    localparam logic [7:0] c_cmd_disp_on  = 8'h0C;
    localparam logic [7:0] c_cmd_clear    = 8'h01;
    localparam logic [7:0] c_cmd_entry    = 8'h06;
    localparam logic [7:0] c_cmd_line1    = 8'h80;
    localparam logic [7:0] c_cmd_line2    = 8'hC0;

    localparam int unsigned c_def_powerup_cyc = 750000;
    localparam int unsigned c_def_setup_cyc   = 2;
    localparam int unsigned c_def_en_cyc      = 25;
    localparam int unsigned c_def_cmd_cyc     = 2000;
    localparam int unsigned c_def_clr_cyc     = 82000;

    localparam logic [5:0] c_last_step = 6'd37;

    // Byte 'pos' of a 16-character string literal, leftmost character first.
    function automatic logic [7:0] str_byte(input logic [127:0] s, input logic [3:0] pos);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (pos == 4'(i)) b = s[127 - 8*i -: 8];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_seq_rom.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_seq_rom
//  Purpose  : 38-entry {rs, byte} write table for the LCD init + text sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_seq_rom
    import lcd_ctrl_pkg::*;
(
    input  logic [5:0] i_idx,
    output logic [8:0] o_entry
);

    localparam logic [127:0] c_line1 = "Hello, World!   ";
    localparam logic [127:0] c_line2 = "FPGA LCD Ctrl   ";

    logic [3:0] w_pos1;
    logic [3:0] w_pos2;

    assign w_pos1 = 4'(i_idx - 6'd5);
    assign w_pos2 = 4'(i_idx - 6'd22);

    always_comb begin
        o_entry = 9'h000;
        case (i_idx)
            6'd0:    o_entry = {1'b0, c_cmd_func_set};
            6'd1:    o_entry = {1'b0, c_cmd_disp_on};
            6'd2:    o_entry = {1'b0, c_cmd_clear};
            6'd3:    o_entry = {1'b0, c_cmd_entry};
            6'd4:    o_entry = {1'b0, c_cmd_line1};
            6'd21:   o_entry = {1'b0, c_cmd_line2};
            default: begin
                if (i_idx >= 6'd5 && i_idx <= 6'd20)
                    o_entry = {1'b1, str_byte(c_line1, w_pos1)};
                else if (i_idx >= 6'd22 && i_idx <= 6'd37)
                    o_entry = {1'b1, str_byte(c_line2, w_pos2)};
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/test_lcd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : test_lcd_controller
//  Purpose  : HD44780 write-only sequencer: power-up wait, init, two text lines.
//  Revision : 1.0 - initial release
// ============================================================================
module test_lcd_controller
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned POWERUP_CYC = c_def_powerup_cyc,
    parameter int unsigned SETUP_CYC   = c_def_setup_cyc,
    parameter int unsigned EN_CYC      = c_def_en_cyc,
    parameter int unsigned CMD_CYC     = c_def_cmd_cyc,
    parameter int unsigned CLR_CYC     = c_def_clr_cyc
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_ON
);

    localparam int unsigned c_max_a   = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
    localparam int unsigned c_max_b   = (CMD_CYC > EN_CYC) ? CMD_CYC : EN_CYC;
    localparam int unsigned c_max_c   = (c_max_b > SETUP_CYC) ? c_max_b : SETUP_CYC;
    localparam int unsigned c_max_cyc = (c_max_a > c_max_c) ? c_max_a : c_max_c;
    localparam int          c_cnt_w   = $clog2(c_max_cyc + 1);

    // Each state lasts N cycles: the counter starts at 0 on entry and exits at N-1.
    localparam logic [c_cnt_w-1:0] c_pwr_last   = c_cnt_w'(POWERUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_en_last    = c_cnt_w'(EN_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cmd_last   = c_cnt_w'(CMD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_clr_last   = c_cnt_w'(CLR_CYC - 1);

    lcd_state_t         r_state;
    lcd_state_t         w_state_nxt;
    logic [5:0]         r_step;
    logic [5:0]         w_step_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_last;
    logic               w_cnt_hit;
    logic               w_load;
    logic [8:0]         w_rom_entry;
    logic [7:0]         r_data;
    logic               r_rs;

    lcd_seq_rom u_seq_rom (
        .i_idx   (w_step_nxt),
        .o_entry (w_rom_entry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_POWERUP;
            r_step  <= 6'd0;
            r_cnt   <= '0;
            r_data  <= 8'h00;
            r_rs    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load) begin
                r_rs   <= w_rom_entry[8];
                r_data <= w_rom_entry[7:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_load      = 1'b0;
        w_cnt_last  = '0;

        case (r_state)
            ST_POWERUP: w_cnt_last = c_pwr_last;
            ST_SETUP:   w_cnt_last = c_setup_last;
            ST_EN_HIGH: w_cnt_last = c_en_last;
            ST_WAIT:    w_cnt_last = (!r_rs && r_data == c_cmd_clear) ? c_clr_last : c_cmd_last;
            default:    w_cnt_last = '0;
        endcase
        w_cnt_hit = (r_cnt == w_cnt_last);

        case (r_state)
            ST_POWERUP: begin
                if (w_cnt_hit) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_cnt_hit) begin
                    w_state_nxt = ST_EN_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            ST_EN_HIGH: begin
                if (w_cnt_hit) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                if (w_cnt_hit) begin
                    w_cnt_nxt = '0;
                    if (r_step == c_last_step) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_step_nxt  = r_step + 6'd1;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_cnt_nxt = r_cnt;
            end
            default: begin
                w_state_nxt = ST_POWERUP;
                w_step_nxt  = 6'd0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign LCD_EN   = (r_state == ST_EN_HIGH);
    assign LCD_RS   = r_rs;
    assign LCD_DATA = r_data;
    assign LCD_RW   = 1'b0;
    assign LCD_ON   = rst;

endmodule
`default_nettype wire

// File: tb/tb_test_lcd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_test_lcd_controller
//  Purpose  : Self-checking bench for test_lcd_controller with short timings.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_test_lcd_controller;

    localparam int unsigned P_PWR = 10;
    localparam int unsigned P_SET = 2;
    localparam int unsigned P_EN  = 3;
    localparam int unsigned P_CMD = 5;
    localparam int unsigned P_CLR = 20;

    logic       clk;
    logic       rst;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;
    logic       LCD_ON;

    test_lcd_controller #(
        .POWERUP_CYC (P_PWR),
        .SETUP_CYC   (P_SET),
        .EN_CYC      (P_EN),
        .CMD_CYC     (P_CMD),
        .CLR_CYC     (P_CLR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .LCD_DATA (LCD_DATA),
        .LCD_RW   (LCD_RW),
        .LCD_EN   (LCD_EN),
        .LCD_RS   (LCD_RS),
        .LCD_ON   (LCD_ON)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference write list and a cycle-by-cycle expected timeline {en, rs, data}.
    logic [8:0] seq [38];
    logic [9:0] exp_q [$];

    task automatic build_model();
        string l1;
        string l2;
        int    wt;
        l1 = "Hello, World!   ";
        l2 = "FPGA LCD Ctrl   ";
        seq[0]  = 9'h038;
        seq[1]  = 9'h00C;
        seq[2]  = 9'h001;
        seq[3]  = 9'h006;
        seq[4]  = 9'h080;
        seq[21] = 9'h0C0;
        for (int i = 0; i < 16; i++) begin
            seq[5 + i]  = {1'b1, l1[i]};
            seq[22 + i] = {1'b1, l2[i]};
        end
        exp_q.delete();
        repeat (P_PWR) exp_q.push_back(10'h000);
        for (int s = 0; s < 38; s++) begin
            wt = (seq[s] == 9'h001) ? P_CLR : P_CMD;
            repeat (P_SET) exp_q.push_back({1'b0, seq[s]});
            repeat (P_EN)  exp_q.push_back({1'b1, seq[s]});
            repeat (wt)    exp_q.push_back({1'b0, seq[s]});
        end
    endtask

    function automatic logic [9:0] model_at(input int k);
        if (k < exp_q.size()) return exp_q[k];
        return {1'b0, seq[37]};
    endfunction

    // Posedges since reset release; index 0 is the first cycle after release.
    int edge_cnt = 0;
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) edge_cnt = 0;
        else      edge_cnt++;
    end

    int         rise_cnt = 0;
    int         fall_cnt = 0;
    int         rise_t [64];
    int         fall_t [64];
    logic [8:0] cap [64];
    logic       prev_en = 1'b0;
    logic [9:0] e;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("rst_en",   LCD_EN,   0);
            chk("rst_rs",   LCD_RS,   0);
            chk("rst_data", LCD_DATA, 0);
            chk("rst_rw",   LCD_RW,   0);
            chk("rst_on",   LCD_ON,   0);
            prev_en  = 1'b0;
            rise_cnt = 0;
            fall_cnt = 0;
        end else begin
            e = model_at(edge_cnt);
            chk("cyc_en",   LCD_EN,   e[9]);
            chk("cyc_rs",   LCD_RS,   e[8]);
            chk("cyc_data", LCD_DATA, e[7:0]);
            chk("cyc_rw",   LCD_RW,   0);
            chk("cyc_on",   LCD_ON,   1);
            if (LCD_EN && !prev_en) begin
                if (rise_cnt < 64) rise_t[rise_cnt] = edge_cnt;
                rise_cnt++;
            end
            if (!LCD_EN && prev_en) begin
                if (fall_cnt < 64) begin
                    fall_t[fall_cnt] = edge_cnt;
                    cap[fall_cnt]    = {LCD_RS, LCD_DATA};
                end
                fall_cnt++;
            end
            prev_en = LCD_EN;
        end
    end

    task automatic wait_rises(input int n, input int lim);
        int k;
        k = 0;
        while (rise_cnt < n && k < lim) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wait_rises_timeout", (rise_cnt >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_falls(input int n, input int lim);
        int k;
        k = 0;
        while (fall_cnt < n && k < lim) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wait_falls_timeout", (fall_cnt >= n) ? 1 : 0, 1);
    endtask

    initial begin
        int wt;
        rst = 1'b0;
        build_model();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Full sequence.
        wait_falls(38, 2000);
        chk("first_rise_cycle", rise_t[0], 12);
        chk("first_write",      cap[0],    9'h038);
        chk("first_en_width",   fall_t[0] - rise_t[0], 3);
        chk("gap_after_0x38",   rise_t[1] - fall_t[0], 7);
        chk("gap_after_clear",  rise_t[3] - fall_t[2], 22);
        chk("cap6_H",           cap[5],    9'h148);
        chk("cap22_line2",      cap[21],   9'h0C0);
        chk("last_fall_cycle",  fall_t[37], 400);
        for (int i = 0; i < 38; i++) begin
            chk("capture", cap[i], seq[i]);
            chk("en_width", fall_t[i] - rise_t[i], P_EN);
        end
        for (int i = 0; i < 37; i++) begin
            wt = (seq[i] == 9'h001) ? P_CLR : P_CMD;
            chk("gap", rise_t[i + 1] - fall_t[i], wt + P_SET);
        end
        repeat (1000) @(negedge clk);
        #1;
        chk("no_write_after_done", rise_cnt, 38);

        // Abort while EN is high during step 7.
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        wait_rises(8, 500);
        @(posedge clk);
        #2;
        chk("abort_en_before", LCD_EN, 1);
        rst = 1'b0;
        #1;
        chk("abort_en",   LCD_EN,   0);
        chk("abort_rs",   LCD_RS,   0);
        chk("abort_data", LCD_DATA, 0);
        chk("abort_on",   LCD_ON,   0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        wait_rises(1, 200);
        chk("restart_rise_cycle", rise_t[0], 12);
        chk("restart_data", LCD_DATA, 8'h38);
        chk("restart_rs",   LCD_RS,   0);
        repeat (100) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/test_lcd_controller.md
TEST_LCD_CONTROLLER -- requirements
Module: test_lcd_controller

Interface
REQ-001 The block SHALL have one clock (clk) and an asynchronous, active-low reset (rst); the polarity and synchronicity of rst are fixed.
REQ-002 Parameter POWERUP_CYC, default 750000, SHALL set the power-on wait before the first write (15 ms at 50 MHz).
REQ-003 Parameter SETUP_CYC, default 2, SHALL set the cycles RS/DATA are stable before EN rises.
REQ-004 Parameter EN_CYC, default 25, SHALL set the EN high-pulse width in cycles (500 ns).
REQ-005 Parameter CMD_CYC, default 2000, SHALL set the wait after EN falls for normal writes (40 us).
REQ-006 Parameter CLR_CYC, default 82000, SHALL set the wait after EN falls for the clear command 0x01 (1.64 ms).
REQ-007 Port clk, input, 1 bit: system clock, 50 MHz nominal, rising edge.
REQ-008 Port rst, input, 1 bit: asynchronous active-low reset.
REQ-009 Port LCD_DATA, output, 8 bits: HD44780 data/command byte.
REQ-010 Port LCD_RW, output, 1 bit: read/write select, constant 0 (write-only).
REQ-011 Port LCD_EN, output, 1 bit: enable strobe; the LCD latches on the falling edge.
REQ-012 Port LCD_RS, output, 1 bit: 0 = command, 1 = character data.
REQ-013 Port LCD_ON, output, 1 bit: LCD power, 1 whenever not in reset.

Function
REQ-014 The write sequence SHALL be a fixed 38-step table, in this order:
- 0x38 function set (8-bit, 2 lines, 5x8)
- 0x0C display on, cursor off
- 0x01 clear
- 0x06 entry mode, increment
- 0x80 line-1 address
- 16 chars "Hello, World!   "
- 0xC0 line-2 address
- 16 chars "FPGA LCD Ctrl   "
REQ-015 Command steps SHALL drive RS=0; character steps SHALL drive RS=1 with the ASCII code.
REQ-016 The FSM states SHALL be POWERUP -> SETUP -> EN_HIGH -> WAIT -> (next step: SETUP | after step 37: DONE).
REQ-017 POWERUP SHALL hold EN=0 for exactly POWERUP_CYC cycles.
REQ-018 SETUP SHALL drive RS/DATA for the current step with EN=0 for SETUP_CYC cycles.
REQ-019 EN_HIGH SHALL hold EN=1 for EN_CYC cycles.
REQ-020 WAIT SHALL hold EN=0 for CMD_CYC cycles, or CLR_CYC if the byte is 0x01.
REQ-021 LCD_DATA and LCD_RS SHALL stay constant from SETUP entry through the end of WAIT (hold time satisfied).
REQ-022 DONE SHALL be terminal: EN=0, last DATA/RS held, no further writes until reset.
REQ-023 A single delay counter, wide enough for max(POWERUP_CYC, CLR_CYC), SHALL reload on every state entry; a state SHALL exit when the counter reaches its programmed count.
REQ-024 The step index SHALL be 6 bits, 0..37, and SHALL never wrap.
REQ-025 Assertion of rst mid-operation, including with EN high, SHALL abort immediately and restart from POWERUP after release.

Reset
REQ-026 While rst=0, the block SHALL hold LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, LCD_ON=0, state=POWERUP, step=0, counter=0.
REQ-027 After release, the first LCD_EN rise SHALL occur exactly POWERUP_CYC+SETUP_CYC cycles later.

Structure
REQ-028 The state enum, the 0x38/0x0C/0x01/0x06/0x80/0xC0 command constants and the default timing constants SHALL be placed in package lcd_ctrl_pkg.
REQ-029 The 38-entry {rs, byte} table SHALL be the sub-module lcd_seq_rom (combinational, 6-bit index in, 9 bits out); the FSM and counter SHALL live in the top module.

Verification
REQ-030 With POWERUP_CYC=10, SETUP_CYC=2, EN_CYC=3, CMD_CYC=5, CLR_CYC=20, after reset release the first EN rise SHALL be at cycle 12 with DATA=0x38, RS=0, and EN high for 3 cycles.
REQ-031 With the same parameters, the EN pulse after 0x01 SHALL be followed by a 20-cycle gap, and every other write by a 5-cycle gap.
REQ-032 The 38 captured EN falling edges SHALL match REQ-014 exactly (e.g. 6th capture RS=1 DATA=0x48 'H'; 22nd capture RS=0 DATA=0xC0), after which EN SHALL stay 0 for 1000 cycles.
REQ-033 Asserting rst while EN=1 during step 7 SHALL drive all outputs to their reset values asynchronously, and after release the sequence SHALL restart with 0x38.
REQ-034 LCD_RW SHALL equal 0 on every cycle, and LCD_ON SHALL equal 1 on every cycle outside reset.
